bv_result_collector: RTL

- Sits directly downstream of the bit-vector TCAM lookup stage.
- That stage has a fixed pipeline, no valid output and no backpressure. This block re-times the lookup valid and a request tag to the four segment results, then stores each result in an output FIFO.
- It presents the FIFO with a ready/valid handshake to the action stage.
- It throttles lookup issue using credits, so a result is never lost when the consumer stalls.

---
 rtl/bv_pkg.sv | 17 +
 rtl/bv_result_fifo.sv | 57 +++++
 rtl/bv_result_collector.sv | 105 ++++++++++
 3 files changed

// File: rtl/bv_pkg.sv
// Shared bit-vector TCAM constants and segment result layout, common to the
// TCAM top and the result collector so both agree on widths and latency.
package bv_pkg;

  localparam int MODE_WIDTH   = 2;
  localparam int RESULT_WIDTH = 32;
  localparam int IDX_WIDTH    = $clog2(RESULT_WIDTH);
  localparam int SEG_NUM      = 4;
  localparam int SEG_W        = MODE_WIDTH + IDX_WIDTH;
  localparam int LATENCY      = 5;

  typedef struct packed {
    logic [MODE_WIDTH-1:0] mode;
    logic [IDX_WIDTH-1:0]  idx;
  } seg_result_t;

endpackage

// File: rtl/bv_result_fifo.sv
// First-word-fall-through FIFO with occupancy output; head data is visible
// combinationally whenever rd_val is high.
module bv_result_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_val,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      level_reg, level_next;
  logic             rd_ok, wr_ok;

  // A write at full is only accepted when the head leaves in the same cycle.
  assign rd_ok = rd_en && (level_reg != '0);
  assign wr_ok = wr_en && ((level_reg != (AW+1)'(DEPTH)) || rd_ok);

  always_comb begin
    level_next = level_reg;
    case ({wr_ok, rd_ok})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_next;
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign rd_val  = (level_reg != '0);
  assign level   = level_reg;

endmodule

// File: rtl/bv_result_collector.sv
// Re-times lookup valid/tag to the TCAM segment results, queues them in an
// FWFT FIFO and gates lookup issue with credits so no result is ever lost.
module bv_result_collector
  import bv_pkg::*;
#(
  parameter int TAG_WIDTH  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LATENCY    = bv_pkg::LATENCY
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          issue_rdy,
  input  logic                          lkp_val,
  input  logic [TAG_WIDTH-1:0]          lkp_tag,
  input  logic [SEG_W-1:0]              seg_01,
  input  logic [SEG_W-1:0]              seg_02,
  input  logic [SEG_W-1:0]              seg_03,
  input  logic [SEG_W-1:0]              seg_04,
  output logic                          res_val,
  input  logic                          res_rdy,
  output logic [TAG_WIDTH-1:0]          res_tag,
  output logic [SEG_NUM*SEG_W-1:0]      res_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf_err
);

  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int DATA_W = TAG_WIDTH + SEG_NUM * SEG_W;

  logic [LVL_W-1:0]     credit_reg, credit_next;
  logic                 ovf_reg, ovf_next;
  logic                 val_pipe_reg [LATENCY];
  logic [TAG_WIDTH-1:0] tag_pipe_reg [LATENCY];
  logic                 accept, pop, wr_en, wr_drop;
  seg_result_t [SEG_NUM-1:0] seg_bus;
  logic [DATA_W-1:0]    wr_data, rd_data;

  assign seg_bus = {seg_04, seg_03, seg_02, seg_01};

  // A lookup without credit is refused here, so it never reaches the FIFO.
  assign accept  = lkp_val && (credit_reg != '0);
  assign pop     = res_val && res_rdy;
  assign wr_en   = val_pipe_reg[LATENCY-1];
  assign wr_drop = wr_en && (fifo_level == LVL_W'(FIFO_DEPTH)) && !pop;
  assign wr_data = {tag_pipe_reg[LATENCY-1], seg_bus};

  always_comb begin
    credit_next = credit_reg;
    case ({accept, pop})
      2'b10:   credit_next = credit_reg - 1'b1;
      2'b01:   credit_next = credit_reg + 1'b1;
      default: credit_next = credit_reg;
    endcase
    ovf_next = ovf_reg || (lkp_val && (credit_reg == '0)) || wr_drop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_reg      <= LVL_W'(FIFO_DEPTH);
      ovf_reg         <= 1'b0;
      val_pipe_reg[0] <= 1'b0;
      tag_pipe_reg[0] <= '0;
    end else begin
      credit_reg      <= credit_next;
      ovf_reg         <= ovf_next;
      val_pipe_reg[0] <= accept;
      tag_pipe_reg[0] <= lkp_tag;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < LATENCY; gi++) begin : g_delay
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          val_pipe_reg[gi] <= 1'b0;
          tag_pipe_reg[gi] <= '0;
        end else begin
          val_pipe_reg[gi] <= val_pipe_reg[gi-1];
          tag_pipe_reg[gi] <= tag_pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  bv_result_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (res_rdy),
    .rd_data (rd_data),
    .rd_val  (res_val),
    .level   (fifo_level)
  );

  assign res_tag   = rd_data[DATA_W-1 -: TAG_WIDTH];
  assign res_data  = rd_data[SEG_NUM*SEG_W-1:0];
  assign issue_rdy = (credit_reg != '0);
  assign ovf_err   = ovf_reg;

endmodule
